// File: rtl/pong_input_cond.sv
// -----------------------------------------------------------------------------
// pong_input_cond
//
// Cleans up the raw player pushbuttons before they reach the pong game core.
// Each channel passes through a two-flop synchroniser and then a counter-based
// debouncer. The block produces three views of every button:
//   - a clean debounced level,
//   - a one-cycle pulse on each debounced press (0->1), used for serve edges,
//   - a frame-held level, so that a tap shorter than one video frame is still
//     visible when the game core samples its inputs on frame_tick.
//
// Parameters
//   N_BTN      number of button channels (p1_up,p1_dn,p1_srv,p2_up,p2_dn,p2_srv)
//   DB_CYCLES  consecutive stable clocks needed to accept a change (>= 2)
//
// Ports
//   clk        in   1      pixel clock
//   rst_n      in   1      asynchronous, active-low reset
//   btn_raw    in   N_BTN  raw asynchronous button inputs, active high
//   frame_tick in   1      one-cycle pulse per frame, synchronous to clk
//   btn_level  out  N_BTN  debounced level
//   btn_rise   out  N_BTN  one-cycle pulse on a debounced 0->1 transition
//   btn_hold   out  N_BTN  btn_level OR press-pending-since-last-frame_tick
// -----------------------------------------------------------------------------
module pong_input_cond #(
  parameter int N_BTN     = 6,
  parameter int DB_CYCLES = 65536
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic             frame_tick,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_rise,
  output logic [N_BTN-1:0] btn_hold
);

  // Counter width is derived from the debounce length and is not overridable.
  localparam int              CNT_W   = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Synchroniser. s1_reg may be metastable, so nothing but s2_reg reads it.
  // ---------------------------------------------------------------------------
  logic [N_BTN-1:0] s1_reg;
  logic [N_BTN-1:0] s2_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_reg <= '0;
      s2_reg <= '0;
    end else begin
      s1_reg <= btn_raw;
      s2_reg <= s1_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // Debouncer state
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_reg  [N_BTN];
  logic [CNT_W-1:0] cnt_next [N_BTN];
  logic [N_BTN-1:0] level_reg;
  logic [N_BTN-1:0] level_next;
  logic [N_BTN-1:0] rise_reg;
  logic [N_BTN-1:0] rise_next;
  logic [N_BTN-1:0] pend_reg;
  logic [N_BTN-1:0] pend_next;
  logic [N_BTN-1:0] accept;

  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_chan
      logic mismatch;
      logic at_max;

      assign mismatch = s2_reg[gi] ^ level_reg[gi];
      assign at_max   = (cnt_reg[gi] == CNT_MAX);

      // A change is accepted on the DB_CYCLES-th consecutive mismatching
      // clock. Any agreement with the current level throws away the run, so
      // a bouncing contact never accumulates partial credit. The counter is
      // cleared on acceptance, which also keeps it from ever wrapping.
      assign accept[gi] = mismatch & at_max;

      assign cnt_next[gi] = (!mismatch || at_max) ? '0
                                                  : cnt_reg[gi] + 1'b1;
    end
  endgenerate

  // Accepting a change always flips the level to the synchronised value.
  assign level_next = level_reg ^ accept;

  // Registered press pulse: high in exactly the cycle btn_level first reads 1.
  assign rise_next = accept & s2_reg;

  // A press arriving in the same cycle as frame_tick belongs to the next
  // frame, so the set term wins over the clear term.
  assign pend_next = rise_reg | (pend_reg & ~{N_BTN{frame_tick}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_BTN; i++) begin
        cnt_reg[i] <= '0;
      end
      level_reg <= '0;
      rise_reg  <= '0;
      pend_reg  <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        cnt_reg[i] <= cnt_next[i];
      end
      level_reg <= level_next;
      rise_reg  <= rise_next;
      pend_reg  <= pend_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all straight from registers; btn_hold is a single OR level)
  // ---------------------------------------------------------------------------
  assign btn_level = level_reg;
  assign btn_rise  = rise_reg;
  assign btn_hold  = level_reg | pend_reg;

endmodule

// File: tb/tb_pong_input_cond.sv
// -----------------------------------------------------------------------------
// tb_pong_input_cond
//
// Self-checking bench for pong_input_cond with DB_CYCLES=4. A reference model
// describes the debouncer as a sliding window over the synchronised samples:
// the level flips when the last DB_CYCLES synchronised samples all disagree
// with it. Directed scenarios pin the model with literal expectations, then a
// randomized bouncy stimulus phase is checked every cycle against the model.
// -----------------------------------------------------------------------------
module tb_pong_input_cond;

  localparam int N  = 6;
  localparam int DB = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] btn_raw;
  logic         frame_tick;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_rise;
  logic [N-1:0] btn_hold;

  int total = 0;
  int bad   = 0;

  pong_input_cond #(
    .N_BTN     (N),
    .DB_CYCLES (DB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .frame_tick (frame_tick),
    .btn_level  (btn_level),
    .btn_rise   (btn_rise),
    .btn_hold   (btn_hold)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model
  // hist[k] is the raw value sampled k edges ago (k=0 is this edge). The value
  // the debouncer sees at an edge is the one sampled two edges earlier.
  // ---------------------------------------------------------------------------
  logic [N-1:0] hist [0:DB+1];
  logic [N-1:0] m_level = '0;
  logic [N-1:0] m_rise  = '0;
  logic [N-1:0] m_pend  = '0;
  logic [N-1:0] m_new_level;
  bit           m_all_differ;

  initial begin
    for (int k = 0; k <= DB + 1; k++) hist[k] = '0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= DB + 1; k++) hist[k] = '0;
      m_level = '0;
      m_rise  = '0;
      m_pend  = '0;
    end else begin
      // pending flag reacts to the pulse visible before this edge
      if (frame_tick) m_pend = m_rise;
      else            m_pend = m_pend | m_rise;
      for (int k = DB + 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = btn_raw;
      m_new_level = m_level;
      for (int c = 0; c < N; c++) begin
        m_all_differ = 1'b1;
        for (int k = 2; k <= DB + 1; k++) begin
          if (hist[k][c] == m_level[c]) m_all_differ = 1'b0;
        end
        if (m_all_differ) m_new_level[c] = ~m_level[c];
      end
      m_rise  = m_new_level & ~m_level;
      m_level = m_new_level;
    end
  end

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  task automatic chk(input string name, input logic [N-1:0] act,
                     input logic [N-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("model_level", btn_level, m_level);
    chk("model_rise",  btn_rise,  m_rise);
    chk("model_hold",  btn_hold,  m_level | m_pend);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame_pulse();
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int           dur [N];
  logic [N-1:0] r;

  initial begin
    rst_n      = 1'b0;
    btn_raw    = 6'h3F;
    frame_tick = 1'b0;

    // 1: reset with all buttons held, then release
    cyc(3);
    chk("rst_level", btn_level, 6'h00);
    chk("rst_rise",  btn_rise,  6'h00);
    chk("rst_hold",  btn_hold,  6'h00);
    rst_n = 1'b1;
    cyc(5);
    chk("s1_level_early", btn_level, 6'h00);
    cyc(1);
    chk("s1_level", btn_level, 6'h3F);
    chk("s1_rise",  btn_rise,  6'h3F);
    chk("s1_hold",  btn_hold,  6'h3F);
    cyc(1);
    chk("s1_rise_gone", btn_rise, 6'h00);
    btn_raw = 6'h00;
    cyc(8);
    frame_pulse();
    chk("s1_hold_clear", btn_hold, 6'h00);

    // 2: bounce on channel 0, settling high
    for (int i = 0; i < 4; i++) begin
      btn_raw[0] = (i % 2 == 0);
      cyc(2);
    end
    btn_raw[0] = 1'b1;
    cyc(5);
    chk("s2_level_early", btn_level & 6'h01, 6'h00);
    cyc(1);
    chk("s2_level", btn_level & 6'h01, 6'h01);
    chk("s2_rise",  btn_rise  & 6'h01, 6'h01);
    cyc(1);
    chk("s2_rise_gone", btn_rise & 6'h01, 6'h00);

    // 3: release of channel 2
    btn_raw[2] = 1'b1;
    cyc(8);
    frame_pulse();
    btn_raw[2] = 1'b0;
    cyc(5);
    chk("s3_level_early", btn_level & 6'h04, 6'h04);
    cyc(1);
    chk("s3_level", btn_level & 6'h04, 6'h00);
    chk("s3_rise",  btn_rise  & 6'h04, 6'h00);

    // 4: short tap on channel 3 with no frame_tick
    btn_raw[3] = 1'b1;
    cyc(8);
    btn_raw[3] = 1'b0;
    cyc(12);
    chk("s4_level", btn_level & 6'h08, 6'h00);
    chk("s4_hold",  btn_hold  & 6'h08, 6'h08);
    frame_tick = 1'b1;
    #1;
    chk("s4_hold_at_tick", btn_hold & 6'h08, 6'h08);
    cyc(1);
    frame_tick = 1'b0;
    chk("s4_hold_clear", btn_hold & 6'h08, 6'h00);

    // 5: frame_tick colliding with a press pulse on channel 4
    btn_raw[4] = 1'b1;
    cyc(6);
    chk("s5_rise", btn_rise & 6'h10, 6'h10);
    frame_pulse();
    chk("s5_hold_after_tick", btn_hold & 6'h10, 6'h10);
    btn_raw[4] = 1'b0;
    cyc(10);
    chk("s5_level", btn_level & 6'h10, 6'h00);
    chk("s5_hold_pending", btn_hold & 6'h10, 6'h10);
    frame_pulse();
    chk("s5_hold_clear", btn_hold & 6'h10, 6'h00);

    // 6: reset in the middle of a count on channel 1
    btn_raw[1] = 1'b1;
    cyc(4);
    rst_n = 1'b0;
    #1;
    chk("s6_rst_level", btn_level, 6'h00);
    chk("s6_rst_hold",  btn_hold,  6'h00);
    chk("s6_rst_rise",  btn_rise,  6'h00);
    cyc(2);
    rst_n = 1'b1;
    cyc(5);
    chk("s6_level_early", btn_level & 6'h02, 6'h00);
    cyc(1);
    chk("s6_level", btn_level & 6'h02, 6'h02);

    // Randomized bouncy buttons, random frame ticks, rare resets
    r = btn_raw;
    for (int c = 0; c < N; c++) dur[c] = $urandom_range(1, 8);
    for (int t = 0; t < 4000; t++) begin
      for (int c = 0; c < N; c++) begin
        dur[c]--;
        if (dur[c] <= 0) begin
          r[c] = ~r[c];
          if ($urandom_range(0, 2) == 0) dur[c] = $urandom_range(4, 20);
          else                           dur[c] = $urandom_range(1, 5);
        end
      end
      btn_raw    = r;
      frame_tick = ($urandom_range(0, 11) == 0);
      rst_n      = ($urandom_range(0, 1499) != 0);
      cyc(1);
    end
    rst_n      = 1'b1;
    frame_tick = 1'b0;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
